// File: rtl/qaddsub_pipe.sv
// rtl/qaddsub_pipe.sv - two-stage sign-magnitude fixed-point add/sub with valid/ready
// Stage 1 forms the raw magnitude and sign; stage 2 resolves overflow and normalises zero.
module qaddsub_pipe #(
   parameter int INT_W  = 15,
   parameter int FRAC_W = 16,
   parameter int SAT    = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    op,
   input  logic [INT_W+FRAC_W:0]   add1,
   input  logic [INT_W+FRAC_W:0]   add2,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [INT_W+FRAC_W:0]   sum,
   output logic                    ovf
);

   localparam int MAG_W  = INT_W + FRAC_W;
   localparam int W      = MAG_W + 1;
   localparam bit SAT_EN = (SAT != 0);

   logic             sign_a;
   logic             sign_b;
   logic [MAG_W-1:0] mag_a;
   logic [MAG_W-1:0] mag_b;
   logic [MAG_W:0]   rmag_d;
   logic             rsign_d;

   logic             s1_valid;
   logic [MAG_W:0]   s1_rmag;
   logic             s1_rsign;

   logic             s2_adv;
   logic             s1_adv;

   logic             ovf_d;
   logic [MAG_W-1:0] mag_d;
   logic             sign_d;

   assign sign_a = add1[W-1];
   assign sign_b = add2[W-1] ^ op;
   assign mag_a  = add1[MAG_W-1:0];
   assign mag_b  = add2[MAG_W-1:0];

   // Subtraction is folded into the effective sign of the second operand.
   always_comb begin
      rmag_d  = '0;
      rsign_d = 1'b0;
      if (sign_a == sign_b) begin
         rmag_d  = {1'b0, mag_a} + {1'b0, mag_b};
         rsign_d = sign_a;
      end else if (mag_a > mag_b) begin
         rmag_d  = {1'b0, mag_a - mag_b};
         rsign_d = sign_a;
      end else if (mag_b > mag_a) begin
         rmag_d  = {1'b0, mag_b - mag_a};
         rsign_d = sign_b;
      end
   end

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_rmag  <= '0;
         s1_rsign <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_rmag  <= rmag_d;
            s1_rsign <= rsign_d;
         end
      end
   end

   // Wrap drops the carry; a zero magnitude always leaves with a positive sign.
   always_comb begin
      ovf_d  = s1_rmag[MAG_W];
      mag_d  = s1_rmag[MAG_W-1:0];
      if (ovf_d && SAT_EN)
         mag_d = '1;
      sign_d = s1_rsign && (|mag_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         ovf       <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            sum <= {sign_d, mag_d};
            ovf <= ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_qaddsub_pipe.sv
// tb/tb_qaddsub_pipe.sv - scoreboard bench for qaddsub_pipe, Q15.16 and Q3.4 in both overflow modes
// Instances 0/1 are 32-bit wrap/saturate, 2/3 are 8-bit wrap/saturate; each pair shares stimulus.
module tb_qaddsub_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv_w = 0, op_w = 0, ord_w = 0;
   logic [31:0] a1_w = 0, a2_w = 0;
   logic        rdy_w0, rdy_w1, ov_w0, ov_w1, ovf_w0, ovf_w1;
   logic [31:0] sum_w0, sum_w1;

   logic        iv_n = 0, op_n = 0, ord_n = 0;
   logic [7:0]  a1_n = 0, a2_n = 0;
   logic        rdy_n0, rdy_n1, ov_n0, ov_n1, ovf_n0, ovf_n1;
   logic [7:0]  sum_n0, sum_n1;

   qaddsub_pipe #(.INT_W(15), .FRAC_W(16), .SAT(0)) u_w0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(rdy_w0), .op(op_w),
      .add1(a1_w), .add2(a2_w), .out_valid(ov_w0), .out_ready(ord_w), .sum(sum_w0), .ovf(ovf_w0));
   qaddsub_pipe #(.INT_W(15), .FRAC_W(16), .SAT(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(rdy_w1), .op(op_w),
      .add1(a1_w), .add2(a2_w), .out_valid(ov_w1), .out_ready(ord_w), .sum(sum_w1), .ovf(ovf_w1));
   qaddsub_pipe #(.INT_W(3), .FRAC_W(4), .SAT(0)) u_n0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_n), .in_ready(rdy_n0), .op(op_n),
      .add1(a1_n), .add2(a2_n), .out_valid(ov_n0), .out_ready(ord_n), .sum(sum_n0), .ovf(ovf_n0));
   qaddsub_pipe #(.INT_W(3), .FRAC_W(4), .SAT(1)) u_n1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_n), .in_ready(rdy_n1), .op(op_n),
      .add1(a1_n), .add2(a2_n), .out_valid(ov_n1), .out_ready(ord_n), .sum(sum_n1), .ovf(ovf_n1));

   int passed = 0;
   int total  = 0;

   logic [32:0] q [4][$];
   bit          held_v [4];
   logic [32:0] held   [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: signed integer arithmetic on the represented values.
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic o, input int mw, input bit sat);
      longint maxm, va, vb, r, ar, m;
      bit     ov, sg;
      maxm = (longint'(1) << mw) - 1;
      va = longint'(a) & maxm;
      vb = longint'(b) & maxm;
      if (a[mw]) va = -va;
      if (b[mw]) vb = -vb;
      if (o) vb = -vb;
      r  = va + vb;
      ar = (r < 0) ? -r : r;
      ov = (ar > maxm);
      m  = ov ? (sat ? maxm : (ar & maxm)) : ar;
      sg = (r < 0) && (m != 0);
      model = {ov, 32'(m | (longint'(sg) << mw))};
   endfunction

   function automatic logic [31:0] rand_op(input int mw);
      logic [31:0] mask;
      mask = (32'h1 << mw) - 1;
      case ($urandom_range(0, 7))
         0: rand_op = 32'h0;
         1: rand_op = 32'h1 << mw;
         2: rand_op = mask;
         3: rand_op = mask | (32'h1 << mw);
         default: rand_op = $urandom & (mask | (32'h1 << mw));
      endcase
   endfunction

   task automatic cycle_w(input bit v, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input bit r, output bit acc);
      @(negedge clk);
      iv_w = v; a1_w = a; a2_w = b; op_w = o; ord_w = r;
      #1;
      chk("in_ready_w", rdy_w0, (q[0].size() < 2) || r);
      acc = v && rdy_w0;
      if (acc) begin
         q[0].push_back(model(a, b, o, 31, 0));
         q[1].push_back(model(a, b, o, 31, 1));
      end
   endtask

   task automatic cycle_n(input bit v, input logic [7:0] a, input logic [7:0] b,
                          input logic o, input bit r, output bit acc);
      @(negedge clk);
      iv_n = v; a1_n = a; a2_n = b; op_n = o; ord_n = r;
      #1;
      chk("in_ready_n", rdy_n0, (q[2].size() < 2) || r);
      acc = v && rdy_n0;
      if (acc) begin
         q[2].push_back(model({24'b0, a}, {24'b0, b}, o, 7, 0));
         q[3].push_back(model({24'b0, a}, {24'b0, b}, o, 7, 1));
      end
   endtask

   task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic o,
                           input logic [32:0] e_wrap, input logic [32:0] e_sat);
      bit acc;
      cycle_w(1, a, b, o, 1, acc);
      chk("dir_accept", acc, 1);
      cycle_w(0, 0, 0, 0, 1, acc);
      chk("dir_not_yet", ov_w0, 0);
      cycle_w(0, 0, 0, 0, 1, acc);
      chk("dir_latency", ov_w0, 1);
      chk("dir_wrap", {ovf_w0, sum_w0}, e_wrap);
      chk("dir_sat", {ovf_w1, sum_w1}, e_sat);
   endtask

   task automatic mon(input int id, input logic ov, input logic ord,
                      input logic [31:0] s, input logic f);
      logic [32:0] e;
      if (!ov) begin
         held_v[id] = 0;
      end else if (ord) begin
         held_v[id] = 0;
         if (q[id].size() == 0) begin
            total++;
            $display("FAIL unexpected_out[%0d]: got %0h expected none", id, {f, s});
         end else begin
            e = q[id].pop_front();
            chk($sformatf("result[%0d]", id), {f, s}, e);
         end
      end else begin
         if (held_v[id]) chk($sformatf("hold[%0d]", id), {f, s}, held[id]);
         held_v[id] = 1;
         held[id]   = {f, s};
      end
   endtask

   always @(negedge clk) begin
      #3;
      if (rst_n) begin
         mon(0, ov_w0, ord_w, sum_w0, ovf_w0);
         mon(1, ov_w1, ord_w, sum_w1, ovf_w1);
         mon(2, ov_n0, ord_n, {24'b0, sum_n0}, ovf_n0);
         mon(3, ov_n1, ord_n, {24'b0, sum_n1}, ovf_n1);
      end
   end

   logic [31:0] bp_a [6];
   logic [31:0] bp_b [6];
   logic        bp_o [6];

   initial begin
      bit acc;
      int k;
      #1;
      chk("reset_in_ready", rdy_w0, 1);
      chk("reset_out_valid", {ov_w0, ov_n0}, 0);
      chk("reset_sum", {ovf_w0, sum_w0}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;

      directed(32'h00018000, 32'h00024000, 0, {1'b0, 32'h0003C000}, {1'b0, 32'h0003C000});
      directed(32'h00010000, 32'h00030000, 1, {1'b0, 32'h80020000}, {1'b0, 32'h80020000});
      directed(32'h80008000, 32'h00008000, 0, 33'h0, 33'h0);
      directed(32'h80000000, 32'h80000000, 0, 33'h0, 33'h0);
      directed(32'h00010000, 32'h00010000, 1, 33'h0, 33'h0);
      directed(32'h7FFF0000, 32'h00010000, 0, {1'b1, 32'h0}, {1'b1, 32'h7FFFFFFF});
      directed(32'hFFFF0000, 32'h80010000, 0, {1'b1, 32'h0}, {1'b1, 32'hFFFFFFFF});
      directed(32'hFFFF0000, 32'h00010000, 1, {1'b1, 32'h0}, {1'b1, 32'hFFFFFFFF});

      for (int i = 0; i < 6; i++) begin
         bp_a[i] = rand_op(31); bp_b[i] = rand_op(31); bp_o[i] = 1'($urandom);
      end
      k = 0;
      for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
         cycle_w(1, bp_a[k], bp_b[k], bp_o[k], cyc >= 4, acc);
         if (acc) k++;
         if (cyc == 3) chk("bp_accepted", k, 2);
      end
      chk("bp_all_sent", k, 6);
      repeat (4) cycle_w(0, 0, 0, 0, 1, acc);

      cycle_w(1, rand_op(31), rand_op(31), 0, 0, acc);
      cycle_w(1, rand_op(31), rand_op(31), 1, 0, acc);
      cycle_w(1, rand_op(31), rand_op(31), 0, 0, acc);
      chk("full_rejects", acc, 0);
      iv_w = 0;
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("rst_out_valid", {ov_w0, ov_w1}, 0);
      chk("rst_sum", {ovf_w0, sum_w0, ovf_w1, sum_w1}, 0);
      chk("rst_in_ready", rdy_w0, 1);
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         held_v[i] = 0;
      end
      @(negedge clk);
      rst_n = 1;
      repeat (3) cycle_w(0, 0, 0, 0, 1, acc);
      directed(32'h00018000, 32'h00024000, 0, {1'b0, 32'h0003C000}, {1'b0, 32'h0003C000});

      for (int i = 0; i < 300; i++)
         cycle_w($urandom_range(0, 3) != 0, rand_op(31), rand_op(31), 1'($urandom),
                 $urandom_range(0, 3) != 0, acc);
      for (int i = 0; i < 800; i++)
         cycle_n($urandom_range(0, 3) != 0, 8'(rand_op(7)), 8'(rand_op(7)), 1'($urandom),
                 $urandom_range(0, 2) != 0, acc);

      for (int i = 0; i < 50 && (q[0].size() + q[2].size()) != 0; i++) begin
         cycle_w(0, 0, 0, 0, 1, acc);
         cycle_n(0, 0, 0, 0, 1, acc);
      end
      @(negedge clk);
      #4;
      chk("drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
